mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Arbitrates one SRAM-like memory bus (req / addr_ok / data_ok) between the instruction-fetch requester and the MEM-stage data requester. Grants are round-robin and sticky until address handshake. Responses are returned in order via a requester-ID FIFO that tracks outstanding transactions. It sits between the pipeline stages and the memory bridge; it adds zero cycles to the request and response paths.

## Interface
- MAX_OUT, default 2: maximum outstanding bus transactions (ID FIFO depth, power of two ≥ 2).
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous active-low reset.
- inst_req  in  1  fetch read request; held until inst_addr_ok.
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch read data valid this cycle.
- inst_rdata  out  32  fetch read data (equals bus_rdata).
- data_req  in  1  load/store request; held until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_wstrb  in  4  store byte enables.
- data_addr  in  32  load/store address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  load data valid / store complete this cycle.
- data_rdata  out  32  load data (equals bus_rdata).
- bus_req, bus_wr, bus_wstrb[4], bus_addr[32], bus_wdata[32]  out  request to bridge.
- bus_addr_ok  in  1  bridge accepted request.
- bus_data_ok  in  1  bridge response for oldest outstanding transaction.
- bus_rdata  in  32  response data.
- err_unexp_ok  out  1  sticky: bus_data_ok seen with nothing outstanding.

## Operation
- State: cnt (0..MAX_OUT), ID FIFO (1 bit per entry: 0 = inst, 1 = data; wr_ptr, rd_ptr), lock_vld, lock_id, last_id.
- can_issue = cnt < MAX_OUT. When cnt == MAX_OUT, bus_req = 0 even if bus_data_ok is asserted in the same cycle (no data_ok→req path).
- Grant selection, evaluated when can_issue:
  - If lock_vld and the locked requester's req is still high: grant lock_id.
  - If only one requester asserts req: grant it.
  - If both assert req: grant the requester ≠ last_id.
  - Otherwise: no grant.
- bus_req = grant valid. Bus request fields are muxed from the granted requester; inst grant drives bus_wr = 0, bus_wstrb = 0, bus_wdata = 0.
- inst_addr_ok / data_addr_ok = bus_addr_ok & bus_req & (grant == that requester). The non-granted requester always sees addr_ok = 0.
- Handshake (bus_req & bus_addr_ok):
  - Push grant ID into the FIFO.
  - last_id ← grant; lock_vld ← 0.
- bus_req & ~bus_addr_ok: lock_vld ← 1, lock_id ← grant. Grant stays with this requester until its handshake. If that requester deasserts req, the lock is released (protocol violation, tolerated).
- bus_data_ok with cnt > 0:
  - Pop head.
  - Head 0 → inst_data_ok = 1; head 1 → data_data_ok = 1. Never both.
- bus_data_ok with cnt == 0: no *_data_ok, cnt stays 0, err_unexp_ok ← 1 until reset.
- cnt update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Pointers wrap modulo MAX_OUT.
- Reset (resetn = 0 at a clock edge):
  - cnt = 0, pointers = 0, lock_vld = 0, last_id = 0 (inst), so data wins the first tie.
  - err_unexp_ok = 0.
  - While resetn = 0, bus_req and all *_addr_ok / *_data_ok are forced to 0.
  - Reset mid-transaction discards all outstanding IDs; the bridge is reset together with this block.

## Timing
- Request path is combinational: req → bus_req, bus_addr_ok → *_addr_ok in the same cycle. Zero added latency.
- Response path is combinational: bus_data_ok/bus_rdata → *_data_ok/*_rdata in the same cycle.
- FIFO, cnt, lock and last_id update at the clock edge following the handshake or response.
- A request accepted in cycle N may receive data_ok no earlier than cycle N+1 (bridge property). The arbiter does not check this.
- Back-to-back issue: one handshake per cycle while cnt < MAX_OUT.
- Outputs after reset release: bus_req = 0 unless a req is present, all ok outputs = 0, err_unexp_ok = 0.

## Test plan
- Single load: data_req = 1, addr 0x1C000100, bus_addr_ok in the same cycle, bus_data_ok two cycles later with rdata 0xDEADBEEF → data_addr_ok in cycle 0, data_data_ok = 1 with data_rdata 0xDEADBEEF, inst_data_ok stays 0, cnt returns to 0.
- Tie after reset: both req = 1 every cycle, bus_addr_ok = 1 → grants alternate data, inst, data, inst. Issue stops after 2 handshakes until a bus_data_ok arrives.
- Sticky grant: inst wins while bus_addr_ok = 0 for 3 cycles, then data_req rises → bus_addr stays the inst address until bus_addr_ok. The next grant goes to data.
- In-order routing: issue inst, then a data store (wstrb 0xF), then two bus_data_ok pulses → first pulse gives inst_data_ok, second gives data_data_ok.
- Full and simultaneous: cnt = 2 with both reqs high → bus_req = 0. bus_data_ok pops to cnt = 1; in the next cycle a handshake plus bus_data_ok leaves cnt = 1.
- Error and reset: bus_data_ok with cnt = 0 → no ok outputs, err_unexp_ok = 1. resetn = 0 for one edge → err_unexp_ok = 0, cnt = 0, outstanding IDs discarded.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: SRAM-like req/addr_ok/data_ok bus between a requester (master) and a responder (slave)
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (output req, wr, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin sticky arbiter of fetch/data requesters onto one bus, in-order response routing
module mem_req_arbiter #(
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    mem_req_arbiter_if.slave  inst,
    mem_req_arbiter_if.slave  data,
    mem_req_arbiter_if.master bus,
    output logic              err_unexp_ok
);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [MAX_OUT-1:0] fifo;
    logic               lock_vld;
    logic               lock_id;
    logic               last_id;
    logic               lock_hold;
    logic               gnt_vld;
    logic               gnt_id;
    logic               push;
    logic               pop;
    logic               head;
    logic               unused_inst;
    assign unused_inst = ^{inst.wr, inst.wstrb, inst.wdata};
    // grant selection, bus request mux and same-cycle handshake/response routing
    always_comb begin
        lock_hold     = lock_vld & (lock_id ? data.req : inst.req);
        gnt_id        = lock_hold ? lock_id : (inst.req & data.req) ? ~last_id : data.req;
        gnt_vld       = resetn & (cnt < MAX_CNT) & (inst.req | data.req);
        push          = gnt_vld & bus.addr_ok;
        pop           = resetn & bus.data_ok & (cnt != '0);
        head          = fifo[rd_ptr];
        bus.req       = gnt_vld;
        bus.wr        = gnt_id ? data.wr : 1'b0;
        bus.wstrb     = gnt_id ? data.wstrb : 4'h0;
        bus.wdata     = gnt_id ? data.wdata : 32'h0;
        bus.addr      = gnt_id ? data.addr : inst.addr;
        inst.addr_ok  = push & ~gnt_id;
        data.addr_ok  = push & gnt_id;
        inst.data_ok  = pop & ~head;
        data.data_ok  = pop & head;
        inst.rdata    = bus.rdata;
        data.rdata    = bus.rdata;
    end
    // requester-ID FIFO, outstanding count and sticky unexpected-response flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo         <= '0;
            err_unexp_ok <= 1'b0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= gnt_id;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (bus.data_ok && cnt == '0)
                err_unexp_ok <= 1'b1;
        end
    end
    // grant lock held across address stalls, and round-robin history
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
            last_id  <= 1'b0;
        end else if (push) begin
            lock_vld <= 1'b0;
            last_id  <= gnt_id;
        end else if (gnt_vld) begin
            lock_vld <= 1'b1;
            lock_id  <= gnt_id;
        end else if (lock_vld && !lock_hold) begin
            lock_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic resetn;
    logic err_unexp_ok;
    int   n_cmp = 0;
    int   n_err = 0;
    mem_req_arbiter_if ib ();
    mem_req_arbiter_if db ();
    mem_req_arbiter_if mb ();
    mem_req_arbiter #(.MAX_OUT(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst         (ib),
        .data         (db),
        .bus          (mb),
        .err_unexp_ok (err_unexp_ok)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic do_reset;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask
    initial begin
        resetn = 1'b0;
        ib.req = 0; ib.wr = 0; ib.wstrb = 0; ib.addr = 32'h0000_1000; ib.wdata = 0;
        db.req = 0; db.wr = 0; db.wstrb = 0; db.addr = 32'h0000_2000; db.wdata = 0;
        mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = 0;
        tick();
        db.req = 1; mb.addr_ok = 1; mb.data_ok = 1;
        #1;
        chk("rst_bus_req", {31'b0, mb.req}, 0);
        chk("rst_oks", {28'b0, db.addr_ok, ib.addr_ok, db.data_ok, ib.data_ok}, 0);
        tick();
        db.req = 0; mb.addr_ok = 0; mb.data_ok = 0;
        resetn = 1'b1;
        #1;
        chk("post_rst_bus_req", {31'b0, mb.req}, 0);
        chk("post_rst_err", {31'b0, err_unexp_ok}, 0);
        // single load
        db.req = 1; db.addr = 32'h1C00_0100; mb.addr_ok = 1;
        #1;
        chk("load_bus_req", {31'b0, mb.req}, 1);
        chk("load_bus_addr", mb.addr, 32'h1C00_0100);
        chk("load_addr_ok", {30'b0, db.addr_ok, ib.addr_ok}, 2'b10);
        tick();
        db.req = 0; mb.addr_ok = 0;
        #1;
        chk("load_cnt1", 32'(dut.cnt), 1);
        tick();
        mb.data_ok = 1; mb.rdata = 32'hDEAD_BEEF;
        #1;
        chk("load_data_ok", {30'b0, db.data_ok, ib.data_ok}, 2'b10);
        chk("load_rdata", db.rdata, 32'hDEAD_BEEF);
        tick();
        mb.data_ok = 0;
        #1;
        chk("load_cnt0", 32'(dut.cnt), 0);
        // tie after reset alternates data, inst, then stalls when full
        do_reset();
        db.addr = 32'h0000_2000;
        ib.req = 1; db.req = 1; mb.addr_ok = 1;
        #1;
        chk("tie1_addr_ok", {30'b0, db.addr_ok, ib.addr_ok}, 2'b10);
        chk("tie1_bus_addr", mb.addr, 32'h0000_2000);
        tick();
        chk("tie2_addr_ok", {30'b0, db.addr_ok, ib.addr_ok}, 2'b01);
        chk("tie2_bus_addr", mb.addr, 32'h0000_1000);
        tick();
        chk("full_bus_req", {31'b0, mb.req}, 0);
        chk("full_addr_ok", {30'b0, db.addr_ok, ib.addr_ok}, 0);
        tick();
        mb.data_ok = 1;
        #1;
        chk("full_pop_bus_req", {31'b0, mb.req}, 0);
        chk("full_pop_data_ok", {30'b0, db.data_ok, ib.data_ok}, 2'b10);
        tick();
        chk("simul_addr_ok", {30'b0, db.addr_ok, ib.addr_ok}, 2'b10);
        chk("simul_data_ok", {30'b0, db.data_ok, ib.data_ok}, 2'b01);
        tick();
        ib.req = 0; db.req = 0; mb.addr_ok = 0;
        #1;
        chk("simul_cnt", 32'(dut.cnt), 1);
        chk("drain_data_ok", {30'b0, db.data_ok, ib.data_ok}, 2'b10);
        tick();
        mb.data_ok = 0;
        #1;
        chk("drain_cnt", 32'(dut.cnt), 0);
        // sticky grant held on inst while data rises, inst forces zero write fields
        do_reset();
        ib.req = 1;
        #1;
        chk("stall_bus_addr", mb.addr, 32'h0000_1000);
        tick();
        tick();
        db.req = 1; db.wr = 1; db.wstrb = 4'hF; db.wdata = 32'h55AA_33CC;
        #1;
        chk("sticky_bus_addr", mb.addr, 32'h0000_1000);
        chk("sticky_inst_wr", {27'b0, mb.wr, mb.wstrb}, 0);
        chk("sticky_inst_wdata", mb.wdata, 0);
        tick();
        chk("sticky2_bus_addr", mb.addr, 32'h0000_1000);
        mb.addr_ok = 1;
        #1;
        chk("sticky_hs", {30'b0, db.addr_ok, ib.addr_ok}, 2'b01);
        tick();
        chk("next_grant_data", {30'b0, db.addr_ok, ib.addr_ok}, 2'b10);
        chk("store_fields", {27'b0, mb.wr, mb.wstrb}, 5'h1F);
        chk("store_wdata", mb.wdata, 32'h55AA_33CC);
        tick();
        ib.req = 0; db.req = 0; db.wr = 0; db.wstrb = 0; mb.addr_ok = 0;
        // in-order routing: inst then data
        mb.data_ok = 1; mb.rdata = 32'h1111_2222;
        #1;
        chk("order1", {30'b0, db.data_ok, ib.data_ok}, 2'b01);
        chk("order1_rdata", ib.rdata, 32'h1111_2222);
        tick();
        chk("order2", {30'b0, db.data_ok, ib.data_ok}, 2'b10);
        tick();
        // unexpected response sets sticky error
        chk("unexp_oks", {30'b0, db.data_ok, ib.data_ok}, 0);
        chk("unexp_err_pre", {31'b0, err_unexp_ok}, 0);
        tick();
        mb.data_ok = 0;
        #1;
        chk("unexp_err", {31'b0, err_unexp_ok}, 1);
        chk("unexp_cnt", 32'(dut.cnt), 0);
        tick();
        chk("unexp_err_sticky", {31'b0, err_unexp_ok}, 1);
        // reset with an outstanding inst discards it
        ib.req = 1; mb.addr_ok = 1;
        tick();
        ib.req = 0;
        resetn = 1'b0; db.req = 1; mb.data_ok = 1;
        #1;
        chk("rst_mid_bus_req", {31'b0, mb.req}, 0);
        chk("rst_mid_data_ok", {30'b0, db.data_ok, ib.data_ok}, 0);
        tick();
        resetn = 1'b1; db.req = 0; mb.addr_ok = 0;
        #1;
        chk("rst_err_clear", {31'b0, err_unexp_ok}, 0);
        chk("rst_cnt", 32'(dut.cnt), 0);
        chk("rst_discard", {30'b0, db.data_ok, ib.data_ok}, 0);
        tick();
        mb.data_ok = 0;
        #1;
        chk("rst_discard_err", {31'b0, err_unexp_ok}, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
